// File: rtl/rv32_mod_muldiv.sv
// rv32_mod_muldiv: iterative radix-2 RV32 M-extension multiply/divide unit
module rv32_mod_muldiv #(
    parameter int XLEN      = 32,
    parameter int EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      func,
    input  logic [XLEN-1:0] read0_data,
    input  logic [XLEN-1:0] read1_data,
    input  logic            flush,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        func_q, func_d;
    logic              s0_q, s0_d, s1_q, s1_d, spec_q, spec_d;
    logic [XLEN-1:0]   b_q, b_d, acc_q, acc_d, lo_q, lo_d, result_q, result_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              sg0, sg1, neg0, neg1, div_zero, ovf, special, div_ge;
    logic [XLEN-1:0]   mag0, mag1, spec_val, sub, qfix, rfix, fix_val;
    logic [XLEN:0]     mul_sum, sh;
    logic [2*XLEN-1:0] prod, pfix;

    // Operand decode at accept time: signedness, magnitudes and RISC-V special-case results
    always_comb begin
        sg0      = func[2] ? ~func[0] : (func[1:0] == 2'b01 || func[1:0] == 2'b10);
        sg1      = func[2] ? ~func[0] : (func[1:0] == 2'b01);
        neg0     = sg0 & read0_data[XLEN-1];
        neg1     = sg1 & read1_data[XLEN-1];
        mag0     = neg0 ? -read0_data : read0_data;
        mag1     = neg1 ? -read1_data : read1_data;
        div_zero = func[2] && read1_data == '0;
        ovf      = func[2] && !func[0] && read0_data == {1'b1, {(XLEN-1){1'b0}}} && &read1_data;
        special  = div_zero | ovf;
        spec_val = div_zero ? (func[1] ? read0_data : '1) : (func[1] ? '0 : read0_data);
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide, plus sign fixup
    always_comb begin
        mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        sh      = {acc_q, lo_q[XLEN-1]};
        div_ge  = sh >= {1'b0, b_q};
        sub     = sh[XLEN-1:0] - b_q;
        prod    = {acc_q, lo_q};
        pfix    = (s0_q ^ s1_q) ? -prod : prod;
        qfix    = (s0_q ^ s1_q) ? -lo_q : lo_q;
        rfix    = s0_q ? -acc_q : acc_q;
        fix_val = func_q[2] ? (func_q[1] ? rfix : qfix)
                            : (func_q[1:0] == 2'b00 ? pfix[XLEN-1:0] : pfix[2*XLEN-1:XLEN]);
    end

    // Next-state logic; flush forces IDLE from any state and blocks a same-cycle accept
    always_comb begin
        state_d  = state_q;
        func_d   = func_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        spec_d   = spec_q;
        b_d      = b_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (req_valid && !flush) begin
                func_d   = func;
                s0_d     = neg0;
                s1_d     = neg1;
                spec_d   = special;
                b_d      = mag1;
                acc_d    = '0;
                lo_d     = mag0;
                cnt_d    = CW'(XLEN);
                result_d = special ? spec_val : result_q;
                state_d  = (special && EARLY_OUT != 0) ? DONE : CALC;
            end
            CALC: begin
                cnt_d   = cnt_q - 1'b1;
                acc_d   = func_q[2] ? (div_ge ? sub : sh[XLEN-1:0]) : mul_sum[XLEN:1];
                lo_d    = func_q[2] ? {lo_q[XLEN-2:0], div_ge} : {mul_sum[0], lo_q[XLEN-1:1]};
                state_d = cnt_q == CW'(1) ? FIXUP : CALC;
            end
            FIXUP: begin
                result_d = spec_q ? result_q : fix_val;
                state_d  = DONE;
            end
            DONE:    state_d = rsp_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            func_q   <= '0;
            s0_q     <= 1'b0;
            s1_q     <= 1'b0;
            spec_q   <= 1'b0;
            b_q      <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            func_q   <= func_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            spec_q   <= spec_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == DONE;
    assign result    = result_q;
endmodule

// File: tb/tb_rv32_mod_muldiv.sv
// tb_rv32_mod_muldiv: directed self-checking bench for rv32_mod_muldiv (XLEN=32, both EARLY_OUT settings)
module tb_rv32_mod_muldiv;
    logic        clk = 1'b0, rst = 1'b1, rv0 = 1'b0, rv1 = 1'b0, flush = 1'b0, rsp_ready = 1'b1;
    logic [2:0]  func = '0;
    logic [31:0] a = '0, b = '0;
    logic        rr0, rr1, vv0, vv1;
    logic [31:0] r0, r1;
    int          pass = 0, total = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rv32_mod_muldiv #(.XLEN(32), .EARLY_OUT(1)) u_eo (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rr0), .func(func),
        .read0_data(a), .read1_data(b), .flush(flush), .rsp_valid(vv0),
        .rsp_ready(rsp_ready), .result(r0)
    );

    rv32_mod_muldiv #(.XLEN(32), .EARLY_OUT(0)) u_full (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1), .func(func),
        .read0_data(a), .read1_data(b), .flush(flush), .rsp_valid(vv1),
        .rsp_ready(rsp_ready), .result(r1)
    );

    // Called at a negedge with the chosen unit idle. lat counts edges from the accept edge
    // (1) to the edge that raised rsp_valid inclusive, so an early-out is 1 and a full op is XLEN+2.
    task automatic run_op(input bit sel, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat, output int acc_cyc,
                          output logic v_after, output logic r_after);
        func = f; a = x; b = y;
        if (sel) rv1 = 1'b1; else rv0 = 1'b1;
        @(posedge clk);
        acc_cyc = cyc;
        lat = 1;
        @(negedge clk);
        rv0 = 1'b0; rv1 = 1'b0;
        a = $urandom; b = $urandom; func = 3'($urandom);
        while (!(sel ? vv1 : vv0) && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = sel ? r1 : r0;
        @(posedge clk);
        @(negedge clk);
        v_after = sel ? vv1 : vv0;
        r_after = sel ? rr1 : rr0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (rr0 !== 1'b1 || rr1 !== 1'b1) $display("FAIL reset_req_ready got %b/%b want 1/1", rr0, rr1); else pass++;
        total++; if (vv0 !== 1'b0 || vv1 !== 1'b0) $display("FAIL reset_rsp_valid got %b/%b want 0/0", vv0, vv1); else pass++;
        total++; if (r0 !== 32'h0 || r1 !== 32'h0) $display("FAIL reset_result got %h/%h want 0/0", r0, r1); else pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul;
        logic [31:0] res; int lat, ac; logic va, ra;
        run_op(1'b0, 3'b000, 32'd7, 32'hFFFFFFFD, res, lat, ac, va, ra);
        total++; if (res !== 32'hFFFFFFEB) $display("FAIL mul_result got %h want ffffffeb", res); else pass++;
        total++; if (lat !== 34) $display("FAIL mul_latency got %0d want 34", lat); else pass++;
        total++; if (va !== 1'b0) $display("FAIL mul_valid_one_cycle got %b want 0", va); else pass++;
        total++; if (ra !== 1'b1) $display("FAIL mul_ready_after got %b want 1", ra); else pass++;
        run_op(1'b0, 3'b000, 32'hFFFFFFFE, 32'h00000003, res, lat, ac, va, ra);
        total++; if (res !== 32'hFFFFFFFA) $display("FAIL mul_signed_low got %h want fffffffa", res); else pass++;
    endtask

    task automatic test_mulh;
        logic [2:0]  fs [4] = '{3'b001, 3'b011, 3'b010, 3'b001};
        logic [31:0] xs [4] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ys [4] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h00000002};
        logic [31:0] es [4] = '{32'h40000000, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] res; int lat, ac; logic va, ra;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, fs[i], xs[i], ys[i], res, lat, ac, va, ra);
            total++; if (res !== es[i]) $display("FAIL mulh_%0d got %h want %h", i, res, es[i]); else pass++;
        end
    endtask

    task automatic test_div;
        logic [2:0]  fs [5] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b110};
        logic [31:0] xs [5] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7};
        logic [31:0] ys [5] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE};
        logic [31:0] es [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'd1};
        logic [31:0] res; int lat, ac; logic va, ra;
        for (int i = 0; i < 5; i++) begin
            run_op(1'b0, fs[i], xs[i], ys[i], res, lat, ac, va, ra);
            total++; if (res !== es[i]) $display("FAIL div_%0d got %h want %h", i, res, es[i]); else pass++;
        end
    endtask

    task automatic test_special(input bit sel, input int exp_lat);
        logic [2:0]  fs [6] = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] xs [6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFFB, 32'hFFFFFFFB};
        logic [31:0] ys [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] es [6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFB};
        logic [31:0] res; int lat, ac; logic va, ra;
        for (int i = 0; i < 6; i++) begin
            run_op(sel, fs[i], xs[i], ys[i], res, lat, ac, va, ra);
            total++; if (res !== es[i]) $display("FAIL special_eo%0d_%0d got %h want %h", !sel, i, res, es[i]); else pass++;
            total++; if (lat !== exp_lat) $display("FAIL special_lat_eo%0d_%0d got %0d want %0d", !sel, i, lat, exp_lat); else pass++;
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] res; int lat, ac1, ac2; logic va, ra;
        run_op(1'b0, 3'b101, 32'd1000, 32'd10, res, lat, ac1, va, ra);
        total++; if (res !== 32'd100) $display("FAIL b2b_first got %0d want 100", res); else pass++;
        run_op(1'b0, 3'b111, 32'd1000, 32'd7, res, lat, ac2, va, ra);
        total++; if (res !== 32'd6) $display("FAIL b2b_second got %0d want 6", res); else pass++;
        total++; if (ac2 - ac1 !== 35) $display("FAIL b2b_throughput got %0d want 35", ac2 - ac1); else pass++;
    endtask

    task automatic test_backpressure;
        int n = 0;
        rsp_ready = 1'b0;
        func = 3'b000; a = 32'd6; b = 32'd7; rv0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rv0 = 1'b0;
        while (!vv0 && n < 100) begin @(negedge clk); n++; end
        total++; if (vv0 !== 1'b1) $display("FAIL bp_reach_done got %b want 1", vv0); else pass++;
        func = 3'b000; a = 32'd2; b = 32'd2; rv0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (vv0 !== 1'b1 || r0 !== 32'd42 || rr0 !== 1'b0)
                $display("FAIL bp_hold_%0d got v=%b r=%0d rdy=%b want v=1 r=42 rdy=0", i, vv0, r0, rr0); else pass++;
        end
        rsp_ready = 1'b1; rv0 = 1'b0;
        @(negedge clk);
        total++; if (vv0 !== 1'b0 || rr0 !== 1'b1) $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", vv0, rr0); else pass++;
    endtask

    task automatic test_flush_reset;
        int seen = 0;
        logic [31:0] res; int lat, ac; logic va, ra;
        func = 3'b000; a = 32'd5; b = 32'd9; rv0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rv0 = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++; if (rr0 !== 1'b1 || vv0 !== 1'b0) $display("FAIL flush_idle got rdy=%b v=%b want rdy=1 v=0", rr0, vv0); else pass++;
        repeat (40) begin @(negedge clk); if (vv0) seen++; end
        total++; if (seen !== 0) $display("FAIL flush_no_rsp got %0d valid cycles want 0", seen); else pass++;
        rv0 = 1'b1; flush = 1'b1;
        @(negedge clk);
        rv0 = 1'b0; flush = 1'b0;
        total++; if (rr0 !== 1'b1) $display("FAIL flush_blocks_accept got rdy=%b want 1", rr0); else pass++;
        func = 3'b000; a = 32'd5; b = 32'd9; rv0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rv0 = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (rr0 !== 1'b1 || vv0 !== 1'b0 || r0 !== 32'h0)
            $display("FAIL midop_reset got rdy=%b v=%b r=%h want rdy=1 v=0 r=0", rr0, vv0, r0); else pass++;
        run_op(1'b0, 3'b000, 32'd3, 32'd4, res, lat, ac, va, ra);
        total++; if (res !== 32'd12) $display("FAIL mul_after_reset got %0d want 12", res); else pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special(1'b0, 1);
        test_special(1'b1, 34);
        test_back_to_back();
        test_backpressure();
        test_flush_reset();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/rv32_mod_muldiv.md
Name: rv32_mod_muldiv

Overview:
- Parametrised, multi-cycle integer multiply/divide unit for the RV32 M extension.
- Sits beside the single-cycle ALU in the execute stage and shares the same operand buses.
- Uses an iterative radix-2 datapath (one result bit per cycle) with a valid/ready request and response handshake, so the pipeline stalls while the unit is busy.
- Generalised to XLEN and optionally early-outs on the RISC-V special cases.

Parameters:
- XLEN, 32, operand/result width; even, >= 8.
- EARLY_OUT, 1, 1 = divide-by-zero and signed-overflow results complete without iterating; 0 = they run the full iteration.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle and able to accept a request.
- func  input  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- read0_data  input  XLEN  rs1 operand (multiplicand/dividend).
- read1_data  input  XLEN  rs2 operand (multiplier/divisor).
- flush  input  1  abort any in-flight operation.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- result  output  XLEN  result data.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high. rst wins over every other input.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, result=0, iteration counter 0.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture func and operands. Compute operand signs per func (MULH: both signed; MULHSU: rs1 signed, rs2 unsigned; DIV/REM: both signed; others unsigned). Take magnitudes. Load counter = XLEN. Go to CALC.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter decrements. Go to FIXUP after the step where counter reaches 1, i.e. XLEN CALC cycles.
  - FIXUP: negate the product/quotient/remainder as required. Product sign = sign0 ^ sign1 (signed operands only). Quotient sign = sign0 ^ sign1. Remainder sign = sign of dividend. Select result: low XLEN bits for MUL, high XLEN bits for MULH*. Register result. Go to DONE.
  - DONE: rsp_valid=1 and result stable. On rsp_ready, go to IDLE; req_ready returns the following cycle (no back-to-back accept in the DONE cycle).
- Latency: request accepted at edge N -> rsp_valid high from cycle N+XLEN+2. With rsp_ready held high, throughput is one op per XLEN+3 cycles.
- Special cases, matching the RISC-V spec:
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - DIV of the most negative value by -1 gives the most negative value; the matching REM gives 0.
  - EARLY_OUT=1: these cases go IDLE -> DONE directly, so rsp_valid is high at cycle N+1.
  - EARLY_OUT=0: these cases take the full latency and must produce identical values.
- MUL result equals the low XLEN bits of the product regardless of signedness.
- Backpressure: while rsp_valid=1 && rsp_ready=0, result and rsp_valid are held unchanged indefinitely; inputs are ignored.
- req_valid while busy: ignored (req_ready=0). The request stays pending at the source.
- flush: from any state, go to IDLE next cycle with rsp_valid=0. The response is discarded even if DONE. flush together with req_valid in IDLE does not accept the request.
- Reset mid-operation behaves as flush plus clearing result.
- Operand inputs are sampled only at the accept edge. Later changes have no effect.

Test Plan:
- XLEN=32, MUL 7 * 0xFFFFFFFD, rsp_ready=1 -> result 0xFFFFFFEB; rsp_valid rises exactly 34 cycles after the accept edge and lasts 1 cycle; req_ready high the cycle after.
- Three separate requests with operands 0x80000000, 0x80000000: MULH -> 0x40000000; MULHU -> 0x40000000; MULHSU with 0xFFFFFFFF, 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- EARLY_OUT=1: DIVU 5/0 -> 0xFFFFFFFF at N+1; REM 5/0 -> 5 at N+1; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, both at N+1. Repeat with EARLY_OUT=0 -> same values at N+34.
- Hold rsp_ready=0 for 5 cycles in DONE -> result and rsp_valid unchanged, req_ready=0, a new req_valid is not accepted; release -> IDLE next cycle.
- Assert flush at CALC cycle 10 -> IDLE next cycle with no rsp_valid pulse. Assert rst at CALC cycle 20 -> all outputs at reset values next cycle. A subsequent MUL 3*4 -> 12.
